// File: rtl/chat_checker.sv
// chat_checker: passive response monitor for the count/hold/add datapath.
// It tracks the DUT with a cycle-accurate reference model and compares dout
// against the model every cycle. It keeps saturating pass and error counts and
// captures the first failing sample.
module chat_checker #(
   parameter int W_IN        = 3,
   parameter int W_OUT       = 4,
   parameter int CNT_W       = 8,
   parameter int STOP_ON_ERR = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             dut_rst_n,
   input  logic [1:0]       sel,
   input  logic [W_IN-1:0]  a,
   input  logic [W_IN-1:0]  b,
   input  logic [W_OUT-1:0] dout,
   input  logic             chk_en,
   output logic             synced,
   output logic             err,
   output logic             err_pulse,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [1:0]       first_sel,
   output logic [W_OUT-1:0] first_exp,
   output logic [W_OUT-1:0] first_obs
);

   typedef enum logic [1:0] {
      ST_UNSYNC = 2'd0,
      ST_RUN    = 2'd1,
      ST_FAIL   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [W_OUT-1:0] EXP_ONE = {{(W_OUT-1){1'b0}}, 1'b1};

   state_t           state_r;
   logic [W_OUT-1:0] exp_r;        // predicted current dout
   logic [W_OUT-1:0] exp_nxt_s;
   logic [1:0]       prev_sel_r;   // sel that produced the value in exp_r
   logic             cmp_s;
   logic             mis_s;

   // Reference model: the next value the DUT is expected to produce
   always_comb begin
      exp_nxt_s = exp_r;
      if (!dut_rst_n) begin
         exp_nxt_s = {W_OUT{1'b0}};
      end else begin
         case (sel)
            2'b00:   exp_nxt_s = W_OUT'(a) + W_OUT'(b);
            2'b01:   exp_nxt_s = exp_r;
            2'b10:   exp_nxt_s = exp_r + EXP_ONE;
            2'b11:   exp_nxt_s = {W_OUT{1'b0}};
            default: exp_nxt_s = exp_r;
         endcase
      end
   end

   // A compare is only meaningful in RUN with the DUT out of reset and checking enabled
   always_comb begin
      cmp_s = (state_r == ST_RUN) && chk_en && dut_rst_n;
      if (cmp_s) begin
         mis_s = (dout != exp_r);
      end else begin
         mis_s = 1'b0;
      end
   end

   // Checker state machine, model register, counters and first-failure capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_UNSYNC;
         synced     <= 1'b0;
         exp_r      <= {W_OUT{1'b0}};
         prev_sel_r <= 2'b00;
         err        <= 1'b0;
         err_pulse  <= 1'b0;
         pass_cnt   <= {CNT_W{1'b0}};
         err_cnt    <= {CNT_W{1'b0}};
         first_sel  <= 2'b00;
         first_exp  <= {W_OUT{1'b0}};
         first_obs  <= {W_OUT{1'b0}};
      end else begin
         // The model keeps tracking in every state so a later resync is clean
         exp_r      <= exp_nxt_s;
         prev_sel_r <= sel;
         err_pulse  <= mis_s;

         if (cmp_s && !mis_s && (pass_cnt != CNT_MAX)) begin
            pass_cnt <= pass_cnt + CNT_ONE;
         end

         if (mis_s) begin
            if (err_cnt != CNT_MAX) begin
               err_cnt <= err_cnt + CNT_ONE;
            end
            if (!err) begin
               err       <= 1'b1;
               first_sel <= prev_sel_r;
               first_exp <= exp_r;
               first_obs <= dout;
            end
         end

         case (state_r)
            ST_UNSYNC: begin
               if (!dut_rst_n) begin
                  state_r <= ST_RUN;
                  synced  <= 1'b1;
               end else begin
                  state_r <= ST_UNSYNC;
                  synced  <= 1'b0;
               end
            end
            ST_RUN: begin
               synced <= 1'b1;
               if (mis_s && (STOP_ON_ERR != 0)) begin
                  state_r <= ST_FAIL;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_FAIL: begin
               // Sticky until checker reset; DUT resets do not leave FAIL
               state_r <= ST_FAIL;
               synced  <= 1'b1;
            end
            default: begin
               state_r <= ST_UNSYNC;
               synced  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_chat_checker.sv
// Directed bench for chat_checker. It drives the stimulus, plays the DUT role by
// presenting hand-computed dout values, and checks three checker instances:
// default, stop-on-error, and narrow counters.
module tb_chat_checker;

   logic       clk;
   logic       rst;
   logic       dut_rst_n;
   logic [1:0] sel;
   logic [2:0] a;
   logic [2:0] b;
   logic [3:0] dout;
   logic       chk_en;

   logic       synced0, err0, pulse0;
   logic [7:0] pass0, errc0;
   logic [1:0] fsel0;
   logic [3:0] fexp0, fobs0;

   logic       synced1, err1, pulse1;
   logic [7:0] pass1, errc1;
   logic [1:0] fsel1;
   logic [3:0] fexp1, fobs1;

   logic       synced2, err2, pulse2;
   logic [1:0] pass2, errc2;
   logic [1:0] fsel2;
   logic [3:0] fexp2, fobs2;

   int checks;
   int errors;

   chat_checker #(.W_IN(3), .W_OUT(4), .CNT_W(8), .STOP_ON_ERR(0)) u0 (
      .clk(clk), .rst(rst), .dut_rst_n(dut_rst_n), .sel(sel), .a(a), .b(b),
      .dout(dout), .chk_en(chk_en), .synced(synced0), .err(err0), .err_pulse(pulse0),
      .pass_cnt(pass0), .err_cnt(errc0), .first_sel(fsel0), .first_exp(fexp0),
      .first_obs(fobs0));

   chat_checker #(.W_IN(3), .W_OUT(4), .CNT_W(8), .STOP_ON_ERR(1)) u1 (
      .clk(clk), .rst(rst), .dut_rst_n(dut_rst_n), .sel(sel), .a(a), .b(b),
      .dout(dout), .chk_en(chk_en), .synced(synced1), .err(err1), .err_pulse(pulse1),
      .pass_cnt(pass1), .err_cnt(errc1), .first_sel(fsel1), .first_exp(fexp1),
      .first_obs(fobs1));

   chat_checker #(.W_IN(3), .W_OUT(4), .CNT_W(2), .STOP_ON_ERR(0)) u2 (
      .clk(clk), .rst(rst), .dut_rst_n(dut_rst_n), .sel(sel), .a(a), .b(b),
      .dout(dout), .chk_en(chk_en), .synced(synced2), .err(err2), .err_pulse(pulse2),
      .pass_cnt(pass2), .err_cnt(errc2), .first_sel(fsel2), .first_exp(fexp2),
      .first_obs(fobs2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // One clock: inputs applied on the falling edge, outputs sampled just after the rising edge
   task automatic step(input logic dn, input logic [1:0] s, input logic [2:0] aa,
                       input logic [2:0] bb, input logic [3:0] d, input logic en);
      @(negedge clk);
      rst = 1'b0; dut_rst_n = dn; sel = s; a = aa; b = bb; dout = d; chk_en = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_rst();
      @(negedge clk);
      rst = 1'b1; dut_rst_n = 1'b1; chk_en = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0; errors = 0;
      clk = 1'b0; rst = 1'b1; dut_rst_n = 1'b1; sel = 2'b00;
      a = 3'd0; b = 3'd0; dout = 4'd0; chk_en = 1'b1;

      // Reset state
      do_rst();
      chk("rst_synced",    32'(synced0), 32'd0);
      chk("rst_err",       32'(err0),    32'd0);
      chk("rst_pulse",     32'(pulse0),  32'd0);
      chk("rst_pass",      32'(pass0),   32'd0);
      chk("rst_errcnt",    32'(errc0),   32'd0);
      chk("rst_first_sel", 32'(fsel0),   32'd0);
      chk("rst_first_exp", 32'(fexp0),   32'd0);
      chk("rst_first_obs", 32'(fobs0),   32'd0);

      // No sync: DUT reset never seen, so garbage dout is ignored
      step(1'b1, 2'b10, 3'd0, 3'd0, 4'd9,  1'b1);
      step(1'b1, 2'b10, 3'd0, 3'd0, 4'd3,  1'b1);
      step(1'b1, 2'b10, 3'd0, 3'd0, 4'd12, 1'b1);
      chk("nosync_synced", 32'(synced0), 32'd0);
      chk("nosync_pass",   32'(pass0),   32'd0);
      chk("nosync_errcnt", 32'(errc0),   32'd0);

      // DUT reset pulse synchronises the checker
      step(1'b0, 2'b10, 3'd0, 3'd0, 4'd5, 1'b1);
      chk("sync_synced", 32'(synced0), 32'd1);
      chk("sync_pass",   32'(pass0),   32'd0);

      // Nominal: count x8, hold x2, add 3+4, add 1+5 (dout lags the model by one edge)
      for (int i = 0; i < 8; i++) step(1'b1, 2'b10, 3'd0, 3'd0, 4'(i), 1'b1);
      step(1'b1, 2'b01, 3'd0, 3'd0, 4'd8, 1'b1);
      step(1'b1, 2'b01, 3'd0, 3'd0, 4'd8, 1'b1);
      step(1'b1, 2'b00, 3'd3, 3'd4, 4'd8, 1'b1);
      step(1'b1, 2'b00, 3'd1, 3'd5, 4'd7, 1'b1);
      chk("nom_pass",   32'(pass0),   32'd12);
      chk("nom_err",    32'(err0),    32'd0);
      chk("nom_errcnt", 32'(errc0),   32'd0);
      chk("nom_synced", 32'(synced0), 32'd1);
      chk("nom_pulse",  32'(pulse0),  32'd0);

      // Injected fault: 3+4 expected 7, DUT shows 6
      step(1'b1, 2'b00, 3'd3, 3'd4, 4'd6, 1'b1);
      step(1'b1, 2'b00, 3'd3, 3'd4, 4'd6, 1'b1);
      chk("flt_pulse",     32'(pulse0), 32'd1);
      chk("flt_err",       32'(err0),   32'd1);
      chk("flt_errcnt",    32'(errc0),  32'd1);
      chk("flt_first_sel", 32'(fsel0),  32'd0);
      chk("flt_first_exp", 32'(fexp0),  32'd7);
      chk("flt_first_obs", 32'(fobs0),  32'd6);
      chk("flt_pass",      32'(pass0),  32'd13);
      chk("flt_stop_errcnt", 32'(errc1), 32'd1);

      step(1'b1, 2'b01, 3'd0, 3'd0, 4'd7, 1'b1);
      chk("pulse_one_cycle", 32'(pulse0), 32'd0);
      chk("post_flt_pass",   32'(pass0),  32'd14);

      step(1'b1, 2'b01, 3'd0, 3'd0, 4'd2, 1'b1);
      chk("second_errcnt",     32'(errc0),   32'd2);
      chk("second_first_obs",  32'(fobs0),   32'd6);
      chk("stop_errcnt_frozen", 32'(errc1),  32'd1);
      chk("stop_pass_frozen",  32'(pass1),   32'd13);
      chk("stop_synced",       32'(synced1), 32'd1);

      // chk_en low: wrong dout must not change any count
      for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 3'd0, 3'd0, 4'd9, 1'b0);
      chk("gate_errcnt", 32'(errc0), 32'd2);
      chk("gate_pass",   32'(pass0), 32'd14);

      // Checker reset mid-run with err set
      do_rst();
      chk("mrst_synced",    32'(synced0), 32'd0);
      chk("mrst_err",       32'(err0),    32'd0);
      chk("mrst_errcnt",    32'(errc0),   32'd0);
      chk("mrst_pass",      32'(pass0),   32'd0);
      chk("mrst_first_exp", 32'(fexp0),   32'd0);
      chk("mrst_first_obs", 32'(fobs0),   32'd0);
      chk("mrst_stop_synced", 32'(synced1), 32'd0);
      chk("mrst_stop_errcnt", 32'(errc1),   32'd0);

      // Wrap: 17 counting compares, dout 0..15 then 0
      step(1'b0, 2'b10, 3'd0, 3'd0, 4'd0, 1'b1);
      for (int i = 0; i < 17; i++) step(1'b1, 2'b10, 3'd0, 3'd0, 4'(i), 1'b1);
      chk("wrap_pass",     32'(pass0), 32'd17);
      chk("wrap_err",      32'(err0),  32'd0);
      chk("sat_pass_narrow", 32'(pass2), 32'd3);

      // DUT reset while counting at 5: next compare expects 0
      for (int i = 1; i < 5; i++) step(1'b1, 2'b10, 3'd0, 3'd0, 4'(i), 1'b1);
      step(1'b0, 2'b10, 3'd0, 3'd0, 4'd5, 1'b1);
      step(1'b1, 2'b01, 3'd0, 3'd0, 4'd0, 1'b1);
      chk("dutrst_pass",   32'(pass0), 32'd22);
      chk("dutrst_err",    32'(err0),  32'd0);
      chk("dutrst_errcnt", 32'(errc0), 32'd0);

      // Five mismatches: narrow error counter saturates at 3
      for (int i = 0; i < 5; i++) step(1'b1, 2'b01, 3'd0, 3'd0, 4'd9, 1'b1);
      chk("sat_errcnt_narrow", 32'(errc2),  32'd3);
      chk("sat_errcnt_wide",   32'(errc0),  32'd5);
      chk("sat_pulse",         32'(pulse0), 32'd1);
      chk("sat_first_sel",     32'(fsel0),  32'd1);
      chk("sat_first_exp",     32'(fexp0),  32'd0);
      chk("sat_first_obs",     32'(fobs0),  32'd9);
      chk("sat_stop_errcnt",   32'(errc1),  32'd1);

      // DUT reset does not release FAIL; further mismatches stay uncounted
      step(1'b0, 2'b01, 3'd0, 3'd0, 4'd9, 1'b1);
      chk("dutrst_nopulse", 32'(pulse0), 32'd0);
      step(1'b1, 2'b01, 3'd0, 3'd0, 4'd9, 1'b1);
      chk("fail_sticky_errcnt", 32'(errc1),   32'd1);
      chk("fail_sticky_synced", 32'(synced1), 32'd1);
      chk("after_dutrst_errcnt", 32'(errc0),  32'd6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chat_checker.md
Name: chat_checker

Overview:
- Self-checking response monitor for the count/hold/add datapath: the consuming end of the stimulus interface.
- Passively observes the same sel/a/b stimulus and DUT reset that the bench drives, plus the DUT result dout.
- Runs a cycle-accurate reference model and compares every cycle.
- Reports pass/mismatch counts and latches the first failing sample, so benches can self-check instead of relying on waveform inspection.

Parameters:
- W_IN, 3, operand width of a and b.
- W_OUT, 4, result width (W_IN+1); counter modulus 2^W_OUT.
- CNT_W, 8, width of the saturating pass and error counters.
- STOP_ON_ERR, 0: 1 = enter FAIL on first mismatch and stop comparing; 0 = keep checking.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high checker reset.
- dut_rst_n  in  1  DUT reset as driven by the bench (active low); monitored only.
- sel  in  2  mode: 00 add, 01 hold, 10 count up, 11 clear.
- a  in  W_IN  operand A.
- b  in  W_IN  operand B.
- dout  in  W_OUT  DUT registered result.
- chk_en  in  1  compare enable; when 0, the model still tracks but no compare is made.
- synced  out  1  model aligned with the DUT (state RUN or FAIL).
- err  out  1  sticky, set on the first mismatch.
- err_pulse  out  1  one-cycle pulse in the cycle after each mismatch.
- pass_cnt  out  CNT_W  matching compares, saturating.
- err_cnt  out  CNT_W  mismatching compares, saturating.
- first_sel  out  2  sel in effect when the first mismatched value was produced.
- first_exp  out  W_OUT  expected value at the first mismatch.
- first_obs  out  W_OUT  observed value at the first mismatch.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= UNSYNC.
  - exp_q, prev_sel, all counters, err, err_pulse and all first_* outputs <= 0.
  - rst takes priority over everything, including mid-run.
- Reference model, one register exp_q (the predicted current dout), updated at each edge when rst=0:
  - dut_rst_n=0 -> 0.
  - Otherwise, by sel:
    - 00 -> a+b, zero-extended to W_OUT, no overflow (max 14).
    - 01 -> exp_q.
    - 10 -> exp_q+1 mod 2^W_OUT (15 -> 0).
    - 11 -> 0.
  - prev_sel <= sel every edge.
- Compare timing: at edge k, dout (produced by the DUT at edge k-1) is compared against exp_q (produced by the model at edge k-1). Model update and compare happen at the same edge; there is no extra latency.
- States:
  - UNSYNC: no compares. Edge with dut_rst_n=0 -> RUN.
  - RUN: compare when chk_en=1 and dut_rst_n=1. Match -> pass_cnt++. Mismatch -> err_cnt++ and err_pulse=1 next cycle; if err was 0, latch first_sel=prev_sel, first_exp=exp_q, first_obs=dout and set err. If STOP_ON_ERR=1, a mismatch -> FAIL.
  - FAIL: no compares, counters frozen, model keeps tracking. Leaves only via rst.
  - In RUN or UNSYNC, an edge with dut_rst_n=0 resynchronises to RUN. No compare is made at that edge, since the DUT output is undefined while in reset.
- Counters saturate at 2^CNT_W-1; there is no wrap.
- synced=1 in RUN and FAIL.
- err_pulse is 0 in every cycle not directly following a mismatch.
- Compares are skipped (no count change) when chk_en=0, in UNSYNC, or when dut_rst_n=0.

Test Plan:
- Nominal sequence: rst; dut_rst_n low 1 cycle; sel=10 for 8 cycles; sel=01 for 2; sel=00 with a=3,b=4 then a=1,b=5; DUT correct -> dout 1..8, 8, 8, 7, 6; err=0, err_cnt=0, pass_cnt=12, synced=1.
- Wrap: count 17 cycles after sync -> expected sequence 1..15, 0, 1; pass_cnt=17, err=0.
- Injected fault: in add mode with a=3,b=4, force dout=6 -> err_pulse for 1 cycle, err=1, err_cnt=1, first_sel=00, first_exp=7, first_obs=6. With STOP_ON_ERR=1, a second bad value leaves err_cnt=1 and the state stays in FAIL.
- No sync: drive sel=10 with dut_rst_n held 1 from the start -> synced=0, pass_cnt=0 and err_cnt=0 despite any dout. Then pulse dut_rst_n low -> synced=1.
- Mid-run resets:
  - dut_rst_n low during counting at value 5 -> next compare expects 0, no error.
  - rst high during RUN with err=1 -> all outputs 0, state UNSYNC.
- Saturation and gating: CNT_W=2 with 5 mismatches -> err_cnt=3. chk_en=0 for 3 cycles with wrong dout -> no count change.
